// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - instruction fetch unit with 2-entry {pc, instr} buffer
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a misaligned redirect target raises a sticky fault, flushes the
//               buffer and halts fetching (fetch_pc left unchanged) until reset.
//   undefined : redirect targets are forced word-aligned and fault reads 0.

module imem_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus8,
    output logic        fault
);

    // Fetch address register.
    logic [31:0] fetch_pc_q, fetch_pc_d;

    // Buffer storage: entry 0 is always the head, entry 1 the tail.
    logic [31:0] pc0_q, pc0_d;
    logic [31:0] instr0_q, instr0_d;
    logic [31:0] pc1_q, pc1_d;
    logic [31:0] instr1_q, instr1_d;
    logic [1:0]  count_q, count_d;

    // Handshake / control decode.
    logic        pop;
    logic        push;
    logic        full;
    logic        wr_entry1;
    logic        misaligned;
    logic        halted;
    logic [31:0] redirect_target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    assign misaligned      = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_target = redirect_pc;
    assign halted          = fault_q;
    assign fault           = fault_q;

    // Sticky fault: set by a misaligned redirect, only reset clears it.
    always_comb begin
        fault_d = fault_q;
        if (misaligned) begin
            fault_d = 1'b1;
        end
    end

    // Fault flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign misaligned      = 1'b0;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign halted          = 1'b0;
    assign fault           = 1'b0;
`endif

    assign full = (count_q == 2'd2);
    assign pop  = out_valid && out_ready;

    // A fetch is captured only when nothing is redirecting the stream, fetching
    // is not halted, and there is room (a same-cycle pop frees the head slot).
    assign push = !redirect_valid && !halted && (!full || pop);

    // The new entry lands at index (count - pop): after a pop the old tail has
    // already shifted into the head slot.
    assign wr_entry1 = (count_q == 2'd2 && pop) || (count_q == 2'd1 && !pop);

    // Next-state for fetch_pc and the buffer; redirect overrides push and pop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc0_d      = pc0_q;
        instr0_d   = instr0_q;
        pc1_d      = pc1_q;
        instr1_d   = instr1_q;
        count_d    = count_q;

        if (redirect_valid) begin
            count_d = 2'd0;
            if (!misaligned) begin
                fetch_pc_d = redirect_target;
            end
        end else begin
            if (pop) begin
                pc0_d    = pc1_q;
                instr0_d = instr1_q;
            end
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                if (wr_entry1) begin
                    pc1_d    = fetch_pc_q;
                    instr1_d = imem_rd;
                end else begin
                    pc0_d    = fetch_pc_q;
                    instr0_d = imem_rd;
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            pc0_q      <= 32'h0;
            instr0_q   <= 32'h0;
            pc1_q      <= 32'h0;
            instr1_q   <= 32'h0;
            count_q    <= 2'd0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc0_q      <= pc0_d;
            instr0_q   <= instr0_d;
            pc1_q      <= pc1_d;
            instr1_q   <= instr1_d;
            count_q    <= count_d;
        end
    end

    // Output view of the head entry; zeros while the buffer is empty.
    always_comb begin
        imem_addr    = fetch_pc_q;
        out_valid    = (count_q != 2'd0);
        out_pc       = out_valid ? pc0_q : 32'h0;
        out_instr    = out_valid ? instr0_q : 32'h0;
        out_pc_plus8 = out_pc + 32'd8;
    end

endmodule
